// File: rtl/sequence_display_ctrl_pkg.sv
// Shared types and constants for the sequence display controller.
package sequence_display_ctrl_pkg;

  localparam int SDC_ADDR_WIDTH = 5;
  localparam int SDC_DATA_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_DATA,
    ST_LED_ON,
    ST_LED_OFF,
    ST_DONE
  } disp_state_t;

  // Largest of four timing constants, used to size the cycle timer.
  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sequence_display_ctrl_if.sv
// Control, sequence-memory and LED signals of the display controller.
interface sequence_display_ctrl_if
  import sequence_display_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = SDC_DATA_WIDTH,
  parameter int ADDR_WIDTH = SDC_ADDR_WIDTH
);

  logic                  start;
  logic                  abort;
  logic                  speed;
  logic [ADDR_WIDTH-1:0] seq_len;
  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] led;
  logic                  busy;
  logic                  done;

  // Game FSM / memory / LED side.
  modport master (
    output start, abort, speed, seq_len, mem_rdata,
    input  mem_rd, mem_addr, led, busy, done
  );

  // Display controller side.
  modport slave (
    input  start, abort, speed, seq_len, mem_rdata,
    output mem_rd, mem_addr, led, busy, done
  );

endinterface

// File: rtl/sequence_display_ctrl_cycle_timer.sv
// Loadable down-counter; expired is high while the count sits at 1.
module sequence_display_ctrl_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load takes priority over counting; the counter parks at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == WIDTH'(1));

endmodule

// File: rtl/sequence_display_ctrl.sv
// Plays the stored colour sequence onto the LEDs: fetch, show, blank, repeat.
module sequence_display_ctrl
  import sequence_display_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = SDC_DATA_WIDTH,
  parameter int ADDR_WIDTH = SDC_ADDR_WIDTH,
  parameter int ON_SLOW    = 25_000_000,
  parameter int OFF_SLOW   = 12_500_000,
  parameter int ON_FAST    = 12_500_000,
  parameter int OFF_FAST   = 6_250_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sequence_display_ctrl_if.slave bus
);

  localparam int T_MAX = max_of4(ON_SLOW, OFF_SLOW, ON_FAST, OFF_FAST);
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] ON_SLOW_T  = TW'(ON_SLOW);
  localparam logic [TW-1:0] OFF_SLOW_T = TW'(OFF_SLOW);
  localparam logic [TW-1:0] ON_FAST_T  = TW'(ON_FAST);
  localparam logic [TW-1:0] OFF_FAST_T = TW'(OFF_FAST);

  if (ON_SLOW < 1 || OFF_SLOW < 1 || ON_FAST < 1 || OFF_FAST < 1) begin : g_param_check
    $error("sequence_display_ctrl: all on/off times must be at least 1 cycle");
  end

  disp_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic                  speed_q, speed_d;
  logic [DATA_WIDTH-1:0] item_q, item_d;

  logic                  timer_load;
  logic [TW-1:0]         timer_value;
  logic                  timer_expired;
  logic [TW-1:0]         on_time;
  logic [TW-1:0]         off_time;

  assign on_time  = speed_q ? ON_FAST_T  : ON_SLOW_T;
  assign off_time = speed_q ? OFF_FAST_T : OFF_SLOW_T;

  sequence_display_ctrl_cycle_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  // Next-state logic; abort overrides everything once playback has begun,
  // and the index is cleared whenever we fall back to IDLE.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    speed_d     = speed_q;
    item_d      = item_q;
    timer_load  = 1'b0;
    timer_value = on_time;

    if (state_q != ST_IDLE && bus.abort) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            speed_d = bus.speed;
            len_d   = bus.seq_len;
            idx_d   = '0;
            state_d = (bus.seq_len == '0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_d = ST_WAIT_DATA;
        end
        ST_WAIT_DATA: begin
          item_d      = bus.mem_rdata;
          timer_load  = 1'b1;
          timer_value = on_time;
          state_d     = ST_LED_ON;
        end
        ST_LED_ON: begin
          if (timer_expired) begin
            timer_load  = 1'b1;
            timer_value = off_time;
            state_d     = ST_LED_OFF;
          end
        end
        ST_LED_OFF: begin
          if (timer_expired) begin
            if (idx_q == (len_q - ADDR_WIDTH'(1))) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + ADDR_WIDTH'(1);
              state_d = ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end
        default: begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, index, latched run parameters and the displayed item.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      speed_q <= 1'b0;
      item_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      speed_q <= speed_d;
      item_q  <= item_d;
    end
  end

  assign bus.mem_rd   = (state_q == ST_FETCH);
  assign bus.mem_addr = idx_q;
  assign bus.led      = (state_q == ST_LED_ON) ? item_q : '0;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_sequence_display_ctrl.sv
// Testbench for sequence_display_ctrl with short on/off times.
module tb_sequence_display_ctrl;
  import sequence_display_ctrl_pkg::*;

  localparam int DW    = 4;
  localparam int AW    = 5;
  localparam int ON_S  = 4;
  localparam int OFF_S = 2;
  localparam int ON_F  = 2;
  localparam int OFF_F = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sequence_display_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sequence_display_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .ON_SLOW    (ON_S),
    .OFF_SLOW   (OFF_S),
    .ON_FAST    (ON_F),
    .OFF_FAST   (OFF_F)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [0:31];

  // Sequence memory with one cycle of read latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.mem_rdata <= '0;
    else if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Playback model: a run is a start edge plus latched length and timing;
  // everything else follows from the offset since that edge.
  int edge_cnt = 0;
  bit m_active = 1'b0;
  int m_start  = 0;
  int m_len    = 0;
  int m_on     = 0;
  int m_off    = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
    end else begin
      edge_cnt = edge_cnt + 1;
      if (m_active) begin
        if (bus.abort) m_active = 1'b0;
        else if (edge_cnt - 1 - m_start >= m_len * (2 + m_on + m_off)) m_active = 1'b0;
      end else if (bus.start && !bus.abort) begin
        m_active = 1'b1;
        m_start  = edge_cnt;
        m_len    = int'(bus.seq_len);
        m_on     = bus.speed ? ON_F : ON_S;
        m_off    = bus.speed ? OFF_F : OFF_S;
      end
    end
  end

  function automatic void modelExpect(output logic [DW-1:0] e_led, output logic e_rd,
                                      output logic [AW-1:0] e_addr, output logic e_busy,
                                      output logic e_done);
    int p, t, i, ph;
    e_led = '0; e_rd = 1'b0; e_addr = '0; e_busy = 1'b0; e_done = 1'b0;
    if (m_active) begin
      p = 2 + m_on + m_off;
      t = edge_cnt - m_start;
      e_busy = 1'b1;
      if (t >= m_len * p) begin
        e_done = 1'b1;
        e_addr = (m_len == 0) ? '0 : AW'(m_len - 1);
      end else begin
        i  = t / p;
        ph = t % p;
        e_addr = AW'(i);
        e_rd   = (ph == 0);
        if (ph >= 2 && ph < 2 + m_on) e_led = mem[i];
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s actual=%0h expected=%0h at edge %0d", name, actual, expected, edge_cnt);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic sp, input logic [AW-1:0] len);
    bus.start   = st;
    bus.abort   = ab;
    bus.speed   = sp;
    bus.seq_len = len;
  endtask

  // Event logs gathered every cycle.
  int          done_cnt       = 0;
  int          last_done_edge = -1;
  int          busy_cnt       = 0;
  logic [AW-1:0] rd_log [$];

  // Per-cycle comparison against the model, plus event logging.
  always @(negedge clk) begin
    logic [DW-1:0] e_led;
    logic          e_rd, e_busy, e_done;
    logic [AW-1:0] e_addr;
    modelExpect(e_led, e_rd, e_addr, e_busy, e_done);
    checkOutput("cyc_led", 32'(bus.led), 32'(e_led));
    checkOutput("cyc_mem_rd", 32'(bus.mem_rd), 32'(e_rd));
    checkOutput("cyc_mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    checkOutput("cyc_busy", 32'(bus.busy), 32'(e_busy));
    checkOutput("cyc_done", 32'(bus.done), 32'(e_done));
    if (bus.mem_rd) rd_log.push_back(bus.mem_addr);
    if (bus.done) begin
      done_cnt       = done_cnt + 1;
      last_done_edge = edge_cnt;
    end
    if (bus.busy) busy_cnt = busy_cnt + 1;
  end

  // Pulses start for one cycle; k is the edge count right after the sampling edge.
  task automatic startRun(input logic [AW-1:0] len, input logic sp, output int k);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, sp, len);
    @(posedge clk);
    #1 k = edge_cnt;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, sp, len);
  endtask

  task automatic waitEdge(input int k, input int t);
    int n;
    n = 0;
    while ((edge_cnt - k) < t && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_edge_timeout", 32'(edge_cnt - k), 32'(t));
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    while (bus.busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic clearLogs();
    rd_log.delete();
    done_cnt       = 0;
    busy_cnt       = 0;
    last_done_edge = -1;
  endtask

  initial begin
    int k;
    for (int i = 0; i < 32; i++) mem[i] = DW'(i);
    mem[0] = 4'b0001;
    mem[1] = 4'b0010;
    mem[2] = 4'b0100;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    // Reset values
    #1;
    checkOutput("rst_led", 32'(bus.led), 32'd0);
    checkOutput("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_hold_busy", 32'(bus.busy), 32'd0);

    // Three items, slow: period 8, done 24 edges after the start edge
    clearLogs();
    startRun(5'd3, 1'b0, k);
    waitEdge(k, 4);
    checkOutput("t1_led_item0", 32'(bus.led), 32'h1);
    waitEdge(k, 7);
    checkOutput("t1_led_gap0", 32'(bus.led), 32'h0);
    waitEdge(k, 10);
    checkOutput("t1_led_item1", 32'(bus.led), 32'h2);
    waitEdge(k, 20);
    checkOutput("t1_led_item2", 32'(bus.led), 32'h4);
    waitIdle(60);
    checkOutput("t1_done_time", 32'(last_done_edge - k), 32'd24);
    checkOutput("t1_done_count", 32'(done_cnt), 32'd1);
    checkOutput("t1_rd_count", 32'(rd_log.size()), 32'd3);
    if (rd_log.size() == 3) begin
      checkOutput("t1_rd_addr0", 32'(rd_log[0]), 32'd0);
      checkOutput("t1_rd_addr1", 32'(rd_log[1]), 32'd1);
      checkOutput("t1_rd_addr2", 32'(rd_log[2]), 32'd2);
    end

    // Two items, fast, with speed/seq_len toggled and start re-pulsed mid-run
    mem[0] = 4'b1000;
    mem[1] = 4'b0000;
    clearLogs();
    startRun(5'd2, 1'b1, k);
    waitEdge(k, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd7);
    @(negedge clk);
    checkOutput("t2_led_item0", 32'(bus.led), 32'h8);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd7);
    waitEdge(k, 7);
    checkOutput("t2_led_zero_item", 32'(bus.led), 32'h0);
    checkOutput("t2_busy_mid", 32'(bus.busy), 32'd1);
    waitIdle(60);
    checkOutput("t2_done_time", 32'(last_done_edge - k), 32'd10);
    checkOutput("t2_done_count", 32'(done_cnt), 32'd1);
    checkOutput("t2_rd_count", 32'(rd_log.size()), 32'd2);

    // Empty sequence: straight to done, busy for exactly one cycle
    mem[0] = 4'b0001;
    mem[1] = 4'b0010;
    clearLogs();
    startRun(5'd0, 1'b0, k);
    waitIdle(10);
    repeat (3) @(negedge clk);
    checkOutput("t3_done_time", 32'(last_done_edge - k), 32'd0);
    checkOutput("t3_done_count", 32'(done_cnt), 32'd1);
    checkOutput("t3_rd_count", 32'(rd_log.size()), 32'd0);
    checkOutput("t3_busy_cycles", 32'(busy_cnt), 32'd1);

    // Abort during item 1 on-time, then start+abort together while idle, then restart
    clearLogs();
    startRun(5'd3, 1'b0, k);
    waitEdge(k, 11);
    checkOutput("t4_led_before_abort", 32'(bus.led), 32'h2);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd3);
    @(posedge clk);
    #1;
    checkOutput("t4_abort_led", 32'(bus.led), 32'h0);
    checkOutput("t4_abort_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd3);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd3);
    checkOutput("t4_start_abort_idle", 32'(bus.busy), 32'd0);
    repeat (30) @(negedge clk);
    checkOutput("t4_no_done", 32'(done_cnt), 32'd0);
    rd_log.delete();
    startRun(5'd1, 1'b0, k);
    waitIdle(30);
    checkOutput("t4_restart_rd_count", 32'(rd_log.size()), 32'd1);
    if (rd_log.size() >= 1) checkOutput("t4_restart_addr", 32'(rd_log[0]), 32'd0);
    checkOutput("t4_restart_done", 32'(done_cnt), 32'd1);

    // Asynchronous reset in the middle of item 1 on-time
    clearLogs();
    startRun(5'd3, 1'b0, k);
    waitEdge(k, 11);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_led", 32'(bus.led), 32'd0);
    checkOutput("t5_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("t5_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("t5_rst_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("t5_idle_after_release", 32'(bus.busy), 32'd0);
    checkOutput("t5_no_done", 32'(done_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
